debug_mem_loader: RTL and testbench

DEBUG_MEM_LOADER -- requirements
Module: debug_mem_loader

---
 rtl/debug_mem_loader_pkg.sv | 16 +
 rtl/debug_mem_loader_btn_edge_detect.sv | 19 +
 rtl/debug_mem_loader.sv | 115 +++++++++++
 tb/tb_debug_mem_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/debug_mem_loader_pkg.sv
// Shared definitions for the debug memory loader: FSM encoding and field widths.
package debug_mem_loader_pkg;

   localparam int LOAD_BYTES = 4;
   localparam int ADDR_W     = 15;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_READY,
      ST_WRITE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/debug_mem_loader_btn_edge_detect.sv
// Rising-edge detector for a debounced button level; history resets high so a
// button held through reset must be released before it can act.
module btn_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic btn_prev;

   always_ff @(posedge clk) begin
      if (rst) btn_prev <= 1'b1;
      else     btn_prev <= btn;
   end

   assign rise = btn & ~btn_prev;

endmodule

// File: rtl/debug_mem_loader.sv
// Debug loader: assembles a 32-bit word from four switch bytes and writes it to
// data memory or the register file while the CPU is halted.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | loader disabled (en=0), nothing captured
// ST_COLLECT | shifting in bytes on load presses, commit ignored
// ST_READY   | four bytes held, waiting for commit, loads ignored
// ST_WRITE   | single strobe cycle to the selected target
// ST_DONE    | one-cycle completion pulse, then back to collecting
module debug_mem_loader
   import debug_mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        reg_data,
   input  logic [14:0] switch,
   input  logic        btn_load,
   input  logic        btn_commit,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        data_we,
   output logic        reg_we,
   output logic [1:0]  byte_idx,
   output logic        ready,
   output logic        done,
   output logic [3:0]  sev_seg_1,
   output logic [3:0]  sev_seg_2
);

   state_t state, state_nxt;
   logic   load_rise, commit_rise;
   logic   reg_sel;

   btn_edge_detect u_load_edge (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_load),
      .rise (load_rise)
   );

   btn_edge_detect u_commit_edge (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_commit),
      .rise (commit_rise)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      data_we   = 1'b0;
      reg_we    = 1'b0;
      case (state)
         ST_IDLE:    state_nxt = ST_COLLECT;
         ST_COLLECT: if (load_rise && byte_idx == 2'(LOAD_BYTES - 1)) state_nxt = ST_READY;
         ST_READY: begin
            ready = 1'b1;
            if (commit_rise) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            // strobes are gated by en so dropping en kills them immediately
            data_we   = en & ~reg_sel;
            reg_we    = en & reg_sel & (wr_addr[REG_ADDR_W-1:0] != '0);
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_COLLECT;
         end
         default:    state_nxt = ST_IDLE;
      endcase
      if (!en) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr   <= '0;
         wr_data   <= '0;
         byte_idx  <= '0;
         reg_sel   <= 1'b0;
         sev_seg_1 <= '0;
         sev_seg_2 <= '0;
      end else if (!en) begin
         byte_idx <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: byte_idx <= '0;
            ST_COLLECT: begin
               if (load_rise) begin
                  wr_data   <= {wr_data[23:0], switch[7:0]};
                  byte_idx  <= byte_idx + 2'd1;
                  sev_seg_1 <= switch[3:0];
                  sev_seg_2 <= switch[7:4];
               end
            end
            ST_READY: begin
               if (commit_rise) begin
                  reg_sel <= reg_data;
                  wr_addr <= reg_data ? 32'(switch[REG_ADDR_W-1:0]) : 32'(switch[ADDR_W-1:0]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_mem_loader.sv
// Self-checking bench for debug_mem_loader: table-driven word loads with a
// scoreboard of expected writes, plus hand-written corner sequences.
module tb_debug_mem_loader;

   logic        clk = 1'b0;
   logic        rst, en, reg_data, btn_load, btn_commit;
   logic [14:0] switch;
   logic [31:0] wr_addr, wr_data;
   logic        data_we, reg_we, ready, done;
   logic [1:0]  byte_idx;
   logic [3:0]  sev_seg_1, sev_seg_2;

   debug_mem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .reg_data   (reg_data),
      .switch     (switch),
      .btn_load   (btn_load),
      .btn_commit (btn_commit),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .data_we    (data_we),
      .reg_we     (reg_we),
      .byte_idx   (byte_idx),
      .ready      (ready),
      .done       (done),
      .sev_seg_1  (sev_seg_1),
      .sev_seg_2  (sev_seg_2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bytes;
      logic [14:0] sw;
      logic        rd;
      logic        exp_d;
      logic        exp_r;
      logic [31:0] exp_addr;
   } vec_t;

   typedef struct {
      logic        d;
      logic        r;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_strobe = 0;
   logic        prev_d, prev_r;
   logic [31:0] prev_addr, prev_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: the cycle before each done pulse is the write cycle.
   always @(negedge clk) begin
      if (rst) begin
         n_strobe = 0;
      end else begin
         if (data_we || reg_we) begin
            n_strobe++;
            chk("one_hot_we", 32'(data_we & reg_we), 32'd0);
            chk("we_needs_en", 32'(en), 32'd1);
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_data_we", 32'(prev_d), 32'(e.d));
               chk("sb_reg_we", 32'(prev_r), 32'(e.r));
               chk("sb_wr_addr", prev_addr, e.addr);
               chk("sb_wr_data", prev_data, e.data);
               chk("sb_strobe_cycles", n_strobe, 32'(e.d | e.r));
            end
            n_strobe = 0;
         end
         prev_d    = data_we;
         prev_r    = reg_we;
         prev_addr = wr_addr;
         prev_data = wr_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic press(input logic l, input logic c, input logic [14:0] sw, input logic rd);
      switch     = sw;
      reg_data   = rd;
      btn_load   = l;
      btn_commit = c;
      step();
      btn_load   = 1'b0;
      btn_commit = 1'b0;
      step();
   endtask

   task automatic load(input logic [7:0] b);
      press(1'b1, 1'b0, {7'd0, b}, 1'b0);
   endtask

   task automatic commit_expect(input logic [14:0] sw, input logic rd, input logic d,
                                input logic r, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      e.d = d; e.r = r; e.addr = addr; e.data = data;
      exp_q.push_back(e);
      press(1'b0, 1'b1, sw, rd);
      step();
      chk("done_reached", 32'(exp_q.size()), 32'd0);
      chk("post_done_idx", 32'(byte_idx), 32'd0);
      chk("post_done_pulse", 32'(done), 32'd0);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{32'hDEADBEEF, 15'h0010, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
      vecs[1] = '{32'h0000002A, 15'h0009, 1'b1, 1'b0, 1'b1, 32'h0000_0009};
      vecs[2] = '{32'h11223344, 15'h0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[3] = '{32'h12345678, 15'h7FFF, 1'b0, 1'b1, 1'b0, 32'h0000_7FFF};
      vecs[4] = '{32'hCAFEF00D, 15'h7FE3, 1'b1, 1'b0, 1'b1, 32'h0000_0003};

      rst = 1'b1; en = 1'b0; reg_data = 1'b0; switch = '0;
      btn_load = 1'b0; btn_commit = 1'b0;
      repeat (3) step();
      chk("rst_wr_addr", wr_addr, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_byte_idx", 32'(byte_idx), 32'd0);
      chk("rst_flags", {28'd0, data_we, reg_we, ready, done}, 32'd0);
      chk("rst_sev", {24'd0, sev_seg_2, sev_seg_1}, 32'd0);

      rst = 1'b0; en = 1'b1;
      step();

      foreach (vecs[i]) begin
         for (int j = 0; j < 4; j++) begin
            load(vecs[i].bytes[31-8*j -: 8]);
            chk("vec_byte_idx", 32'(byte_idx), 32'((j + 1) % 4));
         end
         chk("vec_ready", 32'(ready), 32'd1);
         chk("vec_wr_data", wr_data, vecs[i].bytes);
         chk("vec_sev", {24'd0, sev_seg_2, sev_seg_1}, {24'd0, vecs[i].bytes[7:0]});
         commit_expect(vecs[i].sw, vecs[i].rd, vecs[i].exp_d, vecs[i].exp_r,
                       vecs[i].exp_addr, vecs[i].bytes);
      end

      // Early commit ignored, then a fifth load while READY is ignored.
      load(8'hA1); load(8'hB2);
      press(1'b0, 1'b1, 15'h0050, 1'b0);
      chk("early_commit_idx", 32'(byte_idx), 32'd2);
      chk("early_commit_ready", 32'(ready), 32'd0);
      chk("early_commit_strobe", n_strobe, 32'd0);
      load(8'hC3); load(8'hD4);
      chk("ready_after_4", 32'(ready), 32'd1);
      load(8'hFF);
      chk("fifth_load_data", wr_data, 32'hA1B2C3D4);
      chk("fifth_load_sev", {24'd0, sev_seg_2, sev_seg_1}, 32'h0000_00D4);
      commit_expect(15'h0050, 1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'hA1B2C3D4);

      // Simultaneous edges: load acts in COLLECT, commit acts in READY.
      load(8'h01); load(8'h02); load(8'h03);
      press(1'b1, 1'b1, 15'h0004, 1'b0);
      chk("both_collect_ready", 32'(ready), 32'd1);
      chk("both_collect_data", wr_data, 32'h01020304);
      begin
         exp_t e;
         e.d = 1'b1; e.r = 1'b0; e.addr = 32'h0000_0020; e.data = 32'h01020304;
         exp_q.push_back(e);
      end
      press(1'b1, 1'b1, 15'h0020, 1'b0);
      step();
      chk("both_ready_done", 32'(exp_q.size()), 32'd0);

      // en dropped after 3 bytes, then 4 fresh bytes.
      load(8'h99); load(8'h88); load(8'h77);
      en = 1'b0;
      step();
      chk("en_drop_idx", 32'(byte_idx), 32'd0);
      en = 1'b1;
      step();
      chk("en_restore_idx", 32'(byte_idx), 32'd0);
      load(8'h5A); load(8'h6B); load(8'h7C); load(8'h8D);
      chk("en_restore_data", wr_data, 32'h5A6B7C8D);
      chk("en_restore_ready", 32'(ready), 32'd1);

      // en dropped together with a commit press in READY: commit is lost.
      en = 1'b0;
      press(1'b0, 1'b1, 15'h0044, 1'b0);
      step();
      chk("drop_commit_strobe", n_strobe, 32'd0);
      chk("drop_commit_ready", 32'(ready), 32'd0);
      chk("drop_commit_addr", wr_addr, 32'h0000_0020);
      en = 1'b1;
      step();

      // Load button held through reset release.
      rst = 1'b1; btn_load = 1'b1; switch = 15'h005C;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      chk("held_no_capture_idx", 32'(byte_idx), 32'd0);
      chk("held_no_capture_sev", {24'd0, sev_seg_2, sev_seg_1}, 32'd0);
      btn_load = 1'b0;
      step();
      load(8'h5C);
      chk("held_repress_idx", 32'(byte_idx), 32'd1);
      chk("held_sev_1", 32'(sev_seg_1), 32'hC);
      chk("held_sev_2", 32'(sev_seg_2), 32'h5);

      repeat (3) step();
      chk("stray_strobes", n_strobe, 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
